div_pipe_sched: RTL and testbench
=================================

Name: div_pipe_sched

Overview:
- Round-robin scheduler that shares the pipelined divider (32-bit dividend / 16-bit divisor) between NREQ requesters.
- Arbitrates requests and drives the pipeline's go/divisor/dividend inputs.
- Carries a requester tag and a divide-by-zero flag alongside the pipeline in a matching delay line, so each result is routed back to the requester that issued it.
- Supports a drain/flush handshake, so upper-level control can quiesce the divider before reconfiguration or test.

Parameters:
- NREQ, 4, number of requesters (2..8)
- LAT, 17, cycles from pipe_go high to result valid on pipe_quotient/pipe_remainder
- DV_W, 16, divisor width
- DD_W, 32, dividend width
- Q_W, 16, quotient and remainder width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request, held with operands until granted
- req_divisor  in  NREQ*DV_W  packed divisors, requester i at [i*DV_W +: DV_W]
- req_dividend  in  NREQ*DD_W  packed dividends
- gnt  out  NREQ  combinational one-hot grant; operands of the granted requester are captured at the end of that cycle
- pipe_go  out  1  registered go strobe to the divider pipeline
- pipe_divisor  out  DV_W  registered divisor to the pipeline
- pipe_dividend  out  DD_W  registered dividend to the pipeline
- pipe_quotient  in  Q_W  pipeline quotient output
- pipe_remainder  in  Q_W  pipeline remainder output
- resp_valid  out  NREQ  registered one-hot, one-cycle result strobe
- resp_quotient  out  Q_W  registered quotient
- resp_remainder  out  Q_W  registered remainder
- resp_dz  out  1  result came from a zero divisor
- flush_req  in  1  level request to stop issuing and drain
- flush_done  out  1  pipeline empty and no new issue while flush_req is held
- busy  out  1  in-flight count is non-zero

Behaviour:
- Reset (synchronous, active-high; clk only):
  - All outputs go to 0.
  - RR pointer goes to NREQ-1, so requester 0 has first priority.
  - Tag line is cleared, in-flight counter goes to 0, FSM goes to RUN.
  - Reset mid-operation discards all in-flight results; no resp_valid is produced for them.
- Arbitration:
  - gnt = 0 unless state==RUN and flush_req==0.
  - Otherwise the first asserted req starting at (ptr+1) mod NREQ is granted.
  - The pointer updates to the granted index only on a grant.
  - At most one grant per cycle.
  - A requester holding req after a grant is treated as a new request.
- Issue:
  - A grant in cycle t produces pipe_go=1 in t+1, with pipe_divisor/pipe_dividend from the granted requester.
  - pipe_go=0 in cycles without a grant.
  - Operand outputs hold their last value when pipe_go=0.
- Tag line:
  - Shift register, depth LAT, entry = {valid, id[clog2(NREQ)-1:0], dz}.
  - Entry loaded in t+1 alongside pipe_go; dz = (divisor==0).
  - The head entry is aligned with pipe_quotient in cycle t+1+LAT.
- Response, cycle t+2+LAT (grant-to-response latency LAT+2, i.e. 19 at default):
  - resp_valid[id] = 1.
  - If dz=0: resp_quotient/resp_remainder are the registered pipeline values.
  - If dz=1: quotient = all ones, remainder = 0, resp_dz = 1. The pipeline is still issued so slot ordering is preserved.
  - No backpressure: responses cannot be stalled.
- In-flight counter:
  - Width clog2(LAT+3).
  - +1 on grant, -1 on resp_valid; both in the same cycle leaves it unchanged.
  - Never exceeds LAT+2.
- FSM:
  - RUN -> DRAIN when flush_req=1.
  - DRAIN -> FLUSHED when counter==0.
  - FLUSHED: flush_done=1.
  - FLUSHED -> RUN when flush_req=0; grants may resume the following cycle.
  - flush_req dropped while in DRAIN -> RUN.
  - Responses of in-flight operations are still delivered during DRAIN.
- Throughput: one issue per cycle; back-to-back grants to different or same requesters are legal.

Decomposition:
- Package div_sched_pkg:
  - DV_W/DD_W/Q_W defaults
  - FSM state enum {RUN, DRAIN, FLUSHED}
  - tag struct {valid, id, dz}
  - DZ_QUOTIENT constant (all ones)
- One natural sub-module: rr_arbiter (NREQ-wide, pointer register, combinational one-hot grant, update on grant). It is reusable for other shared resources.

Test Plan:
1. Single requester 0 issues dividend=100, divisor=7 -> gnt[0] the same cycle; pipe_go one cycle later; resp_valid[0] 19 cycles after the grant with quotient 14, remainder 2, resp_dz=0.
2. All 4 requesters hold req continuously from reset -> grants 0,1,2,3,0,1 on consecutive cycles; responses return in the same order, each with the matching id.
3. Requester 2 issues divisor=0, dividend=55 -> resp_valid[2] with quotient 0xFFFF, remainder 0, resp_dz=1 at latency 19; neighbouring results are unaffected.
4. flush_req raised after 5 back-to-back issues -> gnt=0 from that cycle; all 5 responses are delivered; flush_done rises the cycle after the counter reaches 0; dropping flush_req resumes grants.
5. Reset asserted with 10 operations in flight -> no resp_valid afterwards; busy=0; the first grant after reset goes to requester 0.
6. Grant and response in the same cycle at steady state -> counter unchanged; busy stays 1; counter never exceeds 19.

Source files
------------

// File: rtl/div_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_sched_pkg
// Description : Shared types and constants for the divider scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package div_sched_pkg;

  localparam int DV_W_DEF = 16;   // divisor width
  localparam int DD_W_DEF = 32;   // dividend width
  localparam int Q_W_DEF  = 16;   // quotient / remainder width
  localparam int ID_W_MAX = 3;    // enough for up to 8 requesters

  // Quotient reported for a divide by zero
  localparam logic [Q_W_DEF-1:0] DZ_QUOTIENT = '1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_FLUSHED = 2'd2
  } sched_state_e;

  // One slot of the tag delay line that shadows the divider pipeline
  typedef struct packed {
    logic                valid;
    logic [ID_W_MAX-1:0] id;
    logic                dz;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : N-way round-robin arbiter, combinational one-hot grant,
//               pointer moves to the granted index only when a grant occurs.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en_i,
  input  logic [N-1:0]   req_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] gnt_idx_o,
  output logic           gnt_any_o
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW:0]   sum;
  logic [IDW-1:0] cand;

  // Search from ptr+1 upward (wrapping) and grant the first active request
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(N)) begin
        sum = sum - (IDW+1)'(N);
      end
      cand = sum[IDW-1:0];
      if (en_i && !gnt_any_o && req_i[cand]) begin
        gnt_any_o   = 1'b1;
        gnt_idx_o   = cand;
        gnt_o[cand] = 1'b1;
      end
    end
    ptr_d = gnt_any_o ? gnt_idx_o : ptr_q;
  end

  // Pointer register; reset to N-1 so index 0 has first priority
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= IDW'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_pipe_sched.sv
`default_nettype none
// ============================================================================
// Module      : div_pipe_sched
// Description : Round-robin scheduler sharing a pipelined divider between
//               NREQ requesters, with tag routing and drain/flush handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module div_pipe_sched
  import div_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 17,
  parameter int DV_W = DV_W_DEF,
  parameter int DD_W = DD_W_DEF,
  parameter int Q_W  = Q_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DV_W-1:0] req_divisor,
  input  logic [NREQ*DD_W-1:0] req_dividend,
  output logic [NREQ-1:0]      gnt,
  output logic                 pipe_go,
  output logic [DV_W-1:0]      pipe_divisor,
  output logic [DD_W-1:0]      pipe_dividend,
  input  logic [Q_W-1:0]       pipe_quotient,
  input  logic [Q_W-1:0]       pipe_remainder,
  output logic [NREQ-1:0]      resp_valid,
  output logic [Q_W-1:0]       resp_quotient,
  output logic [Q_W-1:0]       resp_remainder,
  output logic                 resp_dz,
  input  logic                 flush_req,
  output logic                 flush_done,
  output logic                 busy
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(LAT + 3);
  localparam logic [Q_W-1:0] DZ_Q = {Q_W{DZ_QUOTIENT[0]}};

  sched_state_e state_q, state_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IDW-1:0]  arb_idx;
  logic            arb_any;
  logic            arb_en;
  logic [DV_W-1:0] sel_divisor;
  logic [DD_W-1:0] sel_dividend;

  logic                pipe_go_q;
  logic [DV_W-1:0]     pipe_divisor_q;
  logic [DD_W-1:0]     pipe_dividend_q;
  logic [ID_W_MAX-1:0] issue_id_q;
  logic                issue_dz_q;

  tag_t tag_q [LAT];
  tag_t tag_in;
  tag_t head;

  logic [NREQ-1:0] resp_valid_q;
  logic [Q_W-1:0]  resp_quotient_q;
  logic [Q_W-1:0]  resp_remainder_q;
  logic            resp_dz_q;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          resp_any;

  // Issuing is only allowed while running and no flush is requested
  assign arb_en = (state_q == ST_RUN) && !flush_req;

  rr_arbiter #(.N(NREQ), .IDW(IDW)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .en_i      (arb_en),
    .req_i     (req),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .gnt_any_o (arb_any)
  );

  assign sel_divisor  = req_divisor[arb_idx*DV_W +: DV_W];
  assign sel_dividend = req_dividend[arb_idx*DD_W +: DD_W];

  // Issue stage: go strobe every cycle, operands only captured on a grant
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_go_q       <= 1'b0;
      pipe_divisor_q  <= '0;
      pipe_dividend_q <= '0;
      issue_id_q      <= '0;
      issue_dz_q      <= 1'b0;
    end else begin
      pipe_go_q  <= arb_any;
      issue_id_q <= ID_W_MAX'(arb_idx);
      issue_dz_q <= (sel_divisor == '0);
      if (arb_any) begin
        pipe_divisor_q  <= sel_divisor;
        pipe_dividend_q <= sel_dividend;
      end
    end
  end

  // Tag entry formed from the issue registers, in step with pipe_go
  always_comb begin
    tag_in       = '0;
    tag_in.valid = pipe_go_q;
    tag_in.id    = issue_id_q;
    tag_in.dz    = issue_dz_q;
  end

  // Tag delay line; the last slot lines up with the pipeline result
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign head = tag_q[LAT-1];

  // Response register: route result to its requester, override on zero divisor
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q     <= '0;
      resp_quotient_q  <= '0;
      resp_remainder_q <= '0;
      resp_dz_q        <= 1'b0;
    end else begin
      resp_valid_q <= head.valid ? (NREQ'(1) << head.id) : '0;
      resp_dz_q    <= head.valid && head.dz;
      if (head.valid) begin
        resp_quotient_q  <= head.dz ? DZ_Q : pipe_quotient;
        resp_remainder_q <= head.dz ? '0   : pipe_remainder;
      end
    end
  end

  assign resp_any = |resp_valid_q;

  // In-flight count: up on grant, down on response, unchanged when both
  always_comb begin
    cnt_d = cnt_q;
    if (arb_any && !resp_any) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!arb_any && resp_any) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Flush FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (flush_req) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!flush_req)          state_d = ST_RUN;
        else if (cnt_q == '0)    state_d = ST_FLUSHED;
      end
      ST_FLUSHED: if (!flush_req) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  // FSM state and in-flight counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt            = arb_gnt;
  assign pipe_go        = pipe_go_q;
  assign pipe_divisor   = pipe_divisor_q;
  assign pipe_dividend  = pipe_dividend_q;
  assign resp_valid     = resp_valid_q;
  assign resp_quotient  = resp_quotient_q;
  assign resp_remainder = resp_remainder_q;
  assign resp_dz        = resp_dz_q;
  assign flush_done     = (state_q == ST_FLUSHED);
  assign busy           = (cnt_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_div_pipe_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_pipe_sched
// Description : Self-checking bench for div_pipe_sched with a divider
//               pipeline stand-in and a scoreboard model of the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_pipe_sched;

  localparam int NREQ = 4;
  localparam int LAT  = 17;
  localparam int DV_W = 16;
  localparam int DD_W = 32;
  localparam int Q_W  = 16;
  localparam int RLAT = LAT + 2;
  localparam int M_RUN = 0, M_DRAIN = 1, M_FLUSHED = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NREQ-1:0]      req;
  logic [NREQ*DV_W-1:0] req_divisor;
  logic [NREQ*DD_W-1:0] req_dividend;
  logic [NREQ-1:0]      gnt;
  logic                 pipe_go;
  logic [DV_W-1:0]      pipe_divisor;
  logic [DD_W-1:0]      pipe_dividend;
  logic [Q_W-1:0]       pipe_quotient;
  logic [Q_W-1:0]       pipe_remainder;
  logic [NREQ-1:0]      resp_valid;
  logic [Q_W-1:0]       resp_quotient;
  logic [Q_W-1:0]       resp_remainder;
  logic                 resp_dz;
  logic                 flush_req;
  logic                 flush_done;
  logic                 busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  div_pipe_sched #(.NREQ(NREQ), .LAT(LAT), .DV_W(DV_W), .DD_W(DD_W), .Q_W(Q_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_divisor    (req_divisor),
    .req_dividend   (req_dividend),
    .gnt            (gnt),
    .pipe_go        (pipe_go),
    .pipe_divisor   (pipe_divisor),
    .pipe_dividend  (pipe_dividend),
    .pipe_quotient  (pipe_quotient),
    .pipe_remainder (pipe_remainder),
    .resp_valid     (resp_valid),
    .resp_quotient  (resp_quotient),
    .resp_remainder (resp_remainder),
    .resp_dz        (resp_dz),
    .flush_req      (flush_req),
    .flush_done     (flush_done),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Divider stand-in: LAT stages; zero divisor yields junk the DUT must hide
  logic [Q_W-1:0] pq [LAT];
  logic [Q_W-1:0] pr [LAT];
  always @(posedge clk) begin
    if (pipe_divisor == '0) begin
      pq[0] <= 16'hDEAD;
      pr[0] <= 16'hBEEF;
    end else begin
      pq[0] <= Q_W'(pipe_dividend / 32'(pipe_divisor));
      pr[0] <= Q_W'(pipe_dividend % 32'(pipe_divisor));
    end
    for (int i = 1; i < LAT; i++) begin
      pq[i] <= pq[i-1];
      pr[i] <= pr[i-1];
    end
  end
  assign pipe_quotient  = pq[LAT-1];
  assign pipe_remainder = pr[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard model ----------------
  typedef struct {
    int              due;
    int              id;
    logic [Q_W-1:0]  q;
    logic [Q_W-1:0]  r;
    logic            dz;
  } exp_t;

  exp_t            sb[$];
  exp_t            m_e;
  int              mp, ms, m_cnt, m_gi;
  logic [NREQ-1:0] m_eg, m_rv;
  logic            exp_go;
  logic [DV_W-1:0] exp_dvs, m_d;
  logic [DD_W-1:0] exp_dvd, m_n;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        mp = NREQ - 1;
        ms = M_RUN;
        exp_go = 1'b0;
        exp_dvs = '0;
        exp_dvd = '0;
      end else begin
        while (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
        m_cnt = sb.size();
        m_eg = '0;
        m_gi = -1;
        if (ms == M_RUN && !flush_req) begin
          for (int k = 1; k <= NREQ; k++) begin
            if (m_gi < 0 && req[(mp + k) % NREQ]) m_gi = (mp + k) % NREQ;
          end
        end
        if (m_gi >= 0) m_eg[m_gi] = 1'b1;
        chk("gnt", 64'(gnt), 64'(m_eg));
        chk("pipe_go", 64'(pipe_go), 64'(exp_go));
        chk("pipe_divisor", 64'(pipe_divisor), 64'(exp_dvs));
        chk("pipe_dividend", 64'(pipe_dividend), 64'(exp_dvd));
        chk("busy", 64'(busy), 64'(m_cnt != 0));
        chk("flush_done", 64'(flush_done), 64'(ms == M_FLUSHED));
        if (sb.size() > 0 && sb[0].due == cyc) begin
          m_rv = '0;
          m_rv[sb[0].id] = 1'b1;
          chk("resp_valid", 64'(resp_valid), 64'(m_rv));
          chk("resp_quotient", 64'(resp_quotient), 64'(sb[0].q));
          chk("resp_remainder", 64'(resp_remainder), 64'(sb[0].r));
          chk("resp_dz", 64'(resp_dz), 64'(sb[0].dz));
        end else begin
          chk("resp_valid_idle", 64'(resp_valid), 64'd0);
        end
        case (ms)
          M_RUN:   if (flush_req) ms = M_DRAIN;
          M_DRAIN: if (!flush_req) ms = M_RUN; else if (m_cnt == 0) ms = M_FLUSHED;
          default: if (!flush_req) ms = M_RUN;
        endcase
        if (m_gi >= 0) begin
          m_d = req_divisor[m_gi*DV_W +: DV_W];
          m_n = req_dividend[m_gi*DD_W +: DD_W];
          m_e.due = cyc + RLAT;
          m_e.id  = m_gi;
          m_e.dz  = (m_d == 0);
          m_e.q   = m_e.dz ? 16'hFFFF : Q_W'(m_n / 32'(m_d));
          m_e.r   = m_e.dz ? 16'h0000 : Q_W'(m_n % 32'(m_d));
          sb.push_back(m_e);
          mp = m_gi;
          exp_go = 1'b1;
          exp_dvs = m_d;
          exp_dvd = m_n;
        end else begin
          exp_go = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int i, input logic on, input logic [DD_W-1:0] n, input logic [DV_W-1:0] d);
    req[i] = on;
    req_dividend[i*DD_W +: DD_W] = n;
    req_divisor[i*DV_W +: DV_W]  = d;
  endtask

  task automatic load_all();
    set_req(0, 1'b1, 32'd1000, 16'd9);
    set_req(1, 1'b1, 32'd50000, 16'd250);
    set_req(2, 1'b1, 32'd55, 16'd0);
    set_req(3, 1'b1, 32'd123456, 16'd1000);
  endtask

  task automatic wait_resp(input logic [NREQ-1:0] m, input int bound, output int at);
    at = -1;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if ((resp_valid & m) != '0) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      failures++;
      $display("FAIL wait_resp: no response for mask %0h within %0d cycles", m, bound);
    end
  endtask

  task automatic wait_idle(input int bound);
    int ok;
    ok = 0;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) begin
      checks++;
      failures++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles", bound);
    end
  endtask

  // ---------------- directed stimulus ----------------
  int g, at, z, nresp;

  initial begin : stim
    req = '0;
    req_divisor = '0;
    req_dividend = '0;
    flush_req = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_pipe_go", 64'(pipe_go), 64'd0);
    chk("rst_pipe_divisor", 64'(pipe_divisor), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_quotient", 64'(resp_quotient), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_flush_done", 64'(flush_done), 64'd0);

    // Single divide 100/7 from requester 0
    @(posedge clk); #1;
    set_req(0, 1'b1, 32'd100, 16'd7);
    @(negedge clk);
    chk("t1_gnt", 64'(gnt), 64'h1);
    g = cyc;
    @(posedge clk); #1 req[0] = 1'b0;
    @(negedge clk);
    chk("t1_pipe_go", 64'(pipe_go), 64'd1);
    chk("t1_pipe_dividend", 64'(pipe_dividend), 64'd100);
    wait_resp(4'b0001, 40, at);
    chk("t1_latency", 64'(at - g), 64'd19);
    chk("t1_quotient", 64'(resp_quotient), 64'd14);
    chk("t1_remainder", 64'(resp_remainder), 64'd2);
    chk("t1_dz", 64'(resp_dz), 64'd0);
    wait_idle(40);

    // All requesters from reset, including a zero divisor on requester 2
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    load_all();
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      if (s == 0) g = cyc;
      chk("t2_gnt_order", 64'(gnt), 64'(1) << (s % 4));
    end
    @(posedge clk); #1 req = '0;
    wait_resp(4'b0100, 40, at);
    chk("t3_latency", 64'(at - (g + 2)), 64'd19);
    chk("t3_quotient", 64'(resp_quotient), 64'hFFFF);
    chk("t3_remainder", 64'(resp_remainder), 64'd0);
    chk("t3_dz", 64'(resp_dz), 64'd1);
    @(negedge clk);
    chk("t3_next_valid", 64'(resp_valid), 64'h8);
    chk("t3_next_quotient", 64'(resp_quotient), 64'd123);
    chk("t3_next_remainder", 64'(resp_remainder), 64'd456);
    chk("t3_next_dz", 64'(resp_dz), 64'd0);
    wait_idle(40);

    // Five back-to-back issues then flush
    @(posedge clk); #1 load_all();
    repeat (5) @(posedge clk);
    #1 flush_req = 1'b1;
    nresp = 0;
    z = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) chk("t4_gnt_off", 64'(gnt), 64'd0);
      if (resp_valid != '0) nresp++;
      if (!busy) begin
        z = cyc;
        break;
      end
    end
    chk("t4_drained", 64'(z >= 0), 64'd1);
    chk("t4_resp_count", 64'(nresp), 64'd5);
    chk("t4_fd_early", 64'(flush_done), 64'd0);
    @(negedge clk);
    chk("t4_flush_done", 64'(flush_done), 64'd1);
    @(posedge clk); #1 flush_req = 1'b0;
    @(negedge clk);
    chk("t4_gnt_hold", 64'(gnt), 64'd0);
    @(negedge clk);
    chk("t4_resume", 64'(gnt != '0), 64'd1);

    // Steady state: grant and response coincide, busy stays high
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("t6_busy", 64'(busy), 64'd1);
    end

    // Reset with many operations in flight
    @(posedge clk); #1;
    reset = 1'b1;
    req = '0;
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk("t5_no_resp", 64'(resp_valid), 64'd0);
      if (k == 0) chk("t5_busy", 64'(busy), 64'd0);
    end
    @(posedge clk); #1;
    set_req(0, 1'b1, 32'd9, 16'd3);
    set_req(3, 1'b1, 32'd8, 16'd2);
    @(negedge clk);
    chk("t5_first_gnt", 64'(gnt), 64'h1);
    @(posedge clk); #1 req = '0;
    wait_idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
